// File: rtl/led_seq.sv
// LED pattern sequencer: walk-left, walk-right, bounce and binary count,
// advanced by a prescaled tick while running or by a manual step while paused.
//
// Bounce direction state:
//   state    | meaning
//   DIR_UP   | lit bit moves toward MSB
//   DIR_DOWN | lit bit moves toward LSB
module led_seq #(
  parameter int N_LED    = 4,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             step_req,
  output logic [N_LED-1:0] led,
  output logic             step
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    P_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    P_ONE  = PW'(1);
  localparam logic [N_LED-1:0] L_ONE  = N_LED'(1);
  localparam logic [N_LED-1:0] L_MSB  = L_ONE << (N_LED - 1);

  localparam logic [1:0] MODE_WALK_L = 2'd0;
  localparam logic [1:0] MODE_WALK_R = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [PW-1:0]    presc_q, presc_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [1:0]       mode_q, mode_d;
  logic             step_q, step_d;
  dir_t             dir_q, dir_d;

  logic tick;
  logic advance;
  logic onehot;

  function automatic logic [N_LED-1:0] start_val(input logic [1:0] m);
    case (m)
      MODE_WALK_L: start_val = L_ONE;
      MODE_WALK_R: start_val = L_MSB;
      MODE_BOUNCE: start_val = L_ONE;
      default:     start_val = '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      led_q   <= L_ONE;
      mode_q  <= MODE_WALK_L;
      step_q  <= 1'b0;
      dir_q   <= DIR_UP;
    end else begin
      presc_q <= presc_d;
      led_q   <= led_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    tick    = en && (presc_q == P_LAST);
    advance = tick || (step_req && !en);
    onehot  = (led_q != '0) && ((led_q & (led_q - L_ONE)) == '0);

    presc_d = presc_q;
    led_d   = led_q;
    mode_d  = mode_q;
    step_d  = 1'b0;
    dir_d   = dir_q;

    if (en) begin
      presc_d = tick ? '0 : presc_q + P_ONE;
    end

    // A mode change wins over a coincident advance and restarts the tick period.
    if (mode != mode_q) begin
      mode_d  = mode;
      led_d   = start_val(mode);
      dir_d   = DIR_UP;
      presc_d = '0;
    end else if (advance) begin
      step_d = 1'b1;
      case (mode_q)
        MODE_WALK_L: led_d = onehot ? {led_q[N_LED-2:0], led_q[N_LED-1]} : L_ONE;
        MODE_WALK_R: led_d = onehot ? {led_q[0], led_q[N_LED-1:1]} : L_MSB;
        MODE_BOUNCE: begin
          if (!onehot) begin
            led_d = L_ONE;
            dir_d = DIR_UP;
          end else if (dir_q == DIR_UP) begin
            if (led_q[N_LED-1]) begin
              led_d = led_q >> 1;
              dir_d = DIR_DOWN;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              led_d = led_q << 1;
              dir_d = DIR_UP;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        default: led_d = led_q + L_ONE;
      endcase
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_seq.sv
// Directed bench for led_seq with N_LED=4, TICK_DIV=4.
module tb_led_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       step_req;
  logic [3:0] led;
  logic       step;

  int n_cmp = 0;
  int n_bad = 0;

  led_seq #(.N_LED(4), .TICK_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .step_req (step_req),
    .led      (led),
    .step     (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance until a step pulse is seen; n is the number of edges taken (20 = timeout).
  task automatic run_to_step(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step && n < 20);
  endtask

  int n;
  logic [3:0] bounce_exp [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                 4'b0010, 4'b0001, 4'b0010, 4'b0100};
  logic [3:0] wl_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'd0; step_req = 1'b1;
    cyc();
    cyc();
    chk("rst_led", led, 4'b0001);
    chk("rst_step", step, 1'b0);

    // walk-left
    rst = 1'b0; step_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_to_step(n);
      chk($sformatf("wl_gap%0d", i), n, 4);
      chk($sformatf("wl_led%0d", i), led, wl_exp[i]);
    end
    cyc();
    chk("wl_step_low", step, 1'b0);

    // bounce
    mode = 2'd2;
    cyc();
    chk("bn_reload_led", led, 4'b0001);
    chk("bn_reload_step", step, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_to_step(n);
      chk($sformatf("bn_gap%0d", i), n, 4);
      chk($sformatf("bn_led%0d", i), led, bounce_exp[i]);
    end

    // binary count wrap
    mode = 2'd3;
    cyc();
    chk("cnt_reload_led", led, 4'b0000);
    for (int i = 1; i <= 17; i++) begin
      run_to_step(n);
      chk($sformatf("cnt_led%0d", i), led, i % 16);
    end

    // pause after 2 cycles of prescaler progress, then manual steps
    cyc();
    cyc();
    en = 1'b0;
    cyc();
    cyc();
    chk("pause_led", led, 4'b0001);
    chk("pause_step", step, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      cyc();
      chk($sformatf("man_step%0d", i), step, 1'b1);
      chk($sformatf("man_led%0d", i), led, 2 + i);
      step_req = 1'b0;
      cyc();
      chk($sformatf("man_idle%0d", i), step, 1'b0);
    end
    step_req = 1'b1;
    cyc();
    cyc();
    chk("held_led", led, 4'd6);
    chk("held_step", step, 1'b1);
    // resume with step_req still high: it must be ignored, tick after 2 edges
    en = 1'b1;
    run_to_step(n);
    chk("resume_gap", n, 2);
    chk("resume_led", led, 4'd7);
    step_req = 1'b0;

    // mode change on the tick cycle
    mode = 2'd0;
    cyc();
    chk("mc_reload0", led, 4'b0001);
    cyc();
    cyc();
    cyc();
    mode = 2'd1;
    cyc();
    chk("mc_led", led, 4'b1000);
    chk("mc_step", step, 1'b0);
    run_to_step(n);
    chk("mc_gap", n, 4);
    chk("mc_next", led, 4'b0100);

    // mid-run reset during bounce, direction down
    mode = 2'd2;
    cyc();
    for (int i = 0; i < 4; i++) run_to_step(n);
    chk("pre_rst_led", led, 4'b0100);
    rst = 1'b1;
    cyc();
    chk("mr_led", led, 4'b0001);
    chk("mr_step", step, 1'b0);
    rst = 1'b0;
    cyc();
    chk("mr_reload_led", led, 4'b0001);
    chk("mr_reload_step", step, 1'b0);
    run_to_step(n);
    chk("mr_gap", n, 4);
    chk("mr_first", led, 4'b0010);
    run_to_step(n);
    chk("mr_second", led, 4'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_seq.md
LED_SEQ -- requirements
Module: led_seq

Interface
REQ-001 The block SHALL have parameter N_LED, default 4, giving the LED count; legal range 2..16.
REQ-002 The block SHALL have parameter TICK_DIV, default 50_000_000, giving clk cycles per automatic step; legal range 2..2^26.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: 1 = run (automatic stepping), 0 = pause.
REQ-006 The block SHALL have port mode, input, 2 bits: pattern select (0 walk-left, 1 walk-right, 2 bounce, 3 binary count).
REQ-007 The block SHALL have port step_req, input, 1 bit: manual single-step request, honoured only while paused.
REQ-008 The block SHALL have port led, output, N_LED bits, registered: current pattern.
REQ-009 The block SHALL have port step, output, 1 bit, registered: one-cycle pulse in the cycle led takes a new stepped value.

Function
REQ-010 The block SHALL keep a prescaler counter (width ceil(log2(TICK_DIV))) counting 0..TICK_DIV-1 while en=1 and holding its value while en=0.
REQ-011 The block SHALL assert the internal signal tick when en=1 and the prescaler equals TICK_DIV-1, with the prescaler wrapping to 0 in the same cycle.
REQ-012 The block SHALL define advance = tick OR (step_req AND NOT en); step_req while en=1 SHALL be ignored, and a held step_req SHALL advance once per cycle.
REQ-013 On advance, led SHALL update on the next rising edge and step SHALL be 1 for exactly that cycle; otherwise step SHALL be 0.
REQ-014 Walk-left SHALL rotate led left by one bit (MSB wraps to LSB); for N_LED=4: 0001,0010,0100,1000,0001.
REQ-015 Walk-right SHALL rotate led right by one bit (LSB wraps to MSB); for N_LED=4: 1000,0100,0010,0001,1000.
REQ-016 Bounce SHALL shift a single one using a direction flag (up = toward MSB) that reverses on reaching bit N_LED-1 or bit 0, with no end value repeated; for N_LED=4: 0001,0010,0100,1000,0100,0010,0001,0010.
REQ-017 Binary count SHALL increment led modulo 2^N_LED, with all-ones wrapping to zero.
REQ-018 Start values SHALL be: walk-left 0..01; walk-right 10..0; bounce 0..01 with direction up; count all-zeros.
REQ-019 The block SHALL register mode internally (mode_q).
REQ-020 When mode differs from mode_q, on the next edge the block SHALL update mode_q, load led with the new mode's start value, clear the prescaler and hold step at 0, and this reload SHALL take priority over a coincident advance.
REQ-021 In walk and bounce modes led SHALL always be one-hot.
REQ-022 If led is not one-hot in those modes (fault), the next advance SHALL load the mode's start value.
REQ-023 Pausing (en 1->0) SHALL freeze led, direction and prescaler.
REQ-024 Resuming SHALL continue from the frozen prescaler value, not from 0.

Reset
REQ-025 While rst=1 on a clock edge, the block SHALL set led = 0..01, step = 0, prescaler = 0, direction = up and mode_q = 0, regardless of other inputs.
REQ-026 Reset SHALL take priority over mode change, advance and step_req.
REQ-027 Reset asserted mid-operation SHALL discard all pattern and prescaler progress.
REQ-028 After release, if mode != 0, the mode-change reload of REQ-020 SHALL occur on the first non-reset edge.

Verification (N_LED=4, TICK_DIV=4)
REQ-029 Bench scenario, walk-left: rst for 2 cycles, then en=1, mode=0 -> step pulses every 4 cycles; led = 0001,0010,0100,1000,0001.
REQ-030 Bench scenario, bounce: mode=2, en=1 for 8 steps -> led = 0010,0100,1000,0100,0010,0001,0010,0100, with no repeat at 1000 or 0001.
REQ-031 Bench scenario, count wrap: mode=3, run 17 steps -> led passes 1111 then 0000, and equals 0001 after step 17.
REQ-032 Bench scenario, pause and manual step: en=0 after 2 cycles of prescaler progress, step_req pulsed 3 times -> led advances 3 steps with 3 step pulses; on re-enabling, the first tick arrives 2 cycles later.
REQ-033 Bench scenario, mode change coincident with tick: mode 0->1 on the tick cycle -> led = 1000, step = 0, prescaler = 0; next step after 4 cycles gives 0100.
REQ-034 Bench scenario, mid-run reset: rst pulsed during bounce with direction down -> led = 0001, step = 0; with mode held at 2, the first non-reset edge reloads 0001 with direction up, and the first tick yields 0010.
